signed_mix_accum: RTL and testbench

- Sequential consumer stage for a mixed-signedness byte bundle: unsigned e, signed f/g/h, all 8-bit.
- Accepts a frame of BEATS beats over a valid/ready handshake and accumulates signed h minus unsigned e at ACC_W width.
- At frame end it applies an arithmetic right shift taken from g, then presents the result and the signed maximum of f on a valid/ready output.
- Exercises signed/unsigned extension, signed compare and >>> across registers in the Verilog-to-FIR flow.

---
 rtl/signed_mix_accum.sv | 127 ++++++++++++
 tb/tb_signed_mix_accum.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_mix_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : signed_mix_accum                                                |
// | Purpose  : frame accumulator of sext(h) - zext(e) with a final >>> by g,   |
// |            and the signed maximum of f; valid/ready in and out.            |
// | Option   : SIGNED_MIX_ACCUM_SATURATE_EN clamps every step to ACC_W.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module signed_mix_accum #(
    parameter int ACC_W = 16,
    parameter int BEATS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       e,
    input  logic [7:0]       f,
    input  logic [7:0]       g,
    input  logic [7:0]       h,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [7:0]       out_max
);

    localparam int                 c_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BEATS - 1);
    localparam int                 c_SUM_W = ACC_W + 2;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [7:0]         r_fmax;
    logic [c_CNT_W-1:0] r_beat_cnt;
    logic [3:0]         r_shamt;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_data;
    logic [7:0]         r_out_max;

    logic               w_accept;
    logic [c_SUM_W-1:0] w_sum;
    logic [ACC_W-1:0]   w_next_acc;
    logic               w_unused;

    assign in_ready  = (r_state == ACC);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_max   = r_out_max;

    // Two guard bits make the sum exact, so wrap and clamp both start from it.
    assign w_sum = {{2{r_acc[ACC_W-1]}}, r_acc}
                 + {{(c_SUM_W-8){h[7]}}, h}
                 - {{(c_SUM_W-8){1'b0}}, e};

    assign w_unused = ^{g[7:4], w_sum[c_SUM_W-1:ACC_W]};

`ifdef SIGNED_MIX_ACCUM_SATURATE_EN
    localparam logic signed [c_SUM_W-1:0] c_MAX = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [c_SUM_W-1:0] c_MIN = {3'b111, {(ACC_W-1){1'b0}}};

    always_comb begin
        w_next_acc = w_sum[ACC_W-1:0];
        if ($signed(w_sum) > c_MAX) begin
            w_next_acc = c_MAX[ACC_W-1:0];
        end else if ($signed(w_sum) < c_MIN) begin
            w_next_acc = c_MIN[ACC_W-1:0];
        end
    end
`else
    assign w_next_acc = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACC;
            r_acc       <= '0;
            r_fmax      <= '0;
            r_beat_cnt  <= '0;
            r_shamt     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_max   <= '0;
        end else begin
            case (r_state)
                ACC: begin
                    if (w_accept) begin
                        r_acc   <= w_next_acc;
                        r_shamt <= g[3:0];
                        if (r_beat_cnt == '0 || $signed(f) > $signed(r_fmax)) begin
                            r_fmax <= f;
                        end
                        if (r_beat_cnt == c_LAST) begin
                            r_beat_cnt <= '0;
                            r_state    <= SHIFT;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
                        end
                    end
                end
                SHIFT: begin
                    r_acc   <= $signed(r_acc) >>> r_shamt;
                    r_state <= HOLD;
                end
                HOLD: begin
                    r_out_data <= r_acc;
                    r_out_max  <= r_fmax;
                    if (out_ready) begin
                        r_acc   <= '0;
                        r_state <= ACC;
                    end
                end
                default: r_state <= ACC;
            endcase
            // Result flag trails the HOLD state by one register stage.
            r_out_valid <= (r_state == HOLD);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_signed_mix_accum.sv
`default_nettype none
// Directed bench: default build, ACC_W=10/BEATS=8 build and BEATS=1 build
// share one stimulus bus; each test resets before it starts.
module tb_signed_mix_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, in_valid, out_ready;
    logic [7:0] e, f, g, h;

    logic        a_in_ready, a_out_valid;
    logic [15:0] a_out_data;
    logic [7:0]  a_out_max;
    logic        b_in_ready, b_out_valid;
    logic [9:0]  b_out_data;
    logic [7:0]  b_out_max;
    logic        c_in_ready, c_out_valid;
    logic [15:0] c_out_data;
    logic [7:0]  c_out_max;

    signed_mix_accum u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .e(e), .f(f), .g(g), .h(h), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_max(a_out_max)
    );

    signed_mix_accum #(.ACC_W(10), .BEATS(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .e(e), .f(f), .g(g), .h(h), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_max(b_out_max)
    );

    signed_mix_accum #(.ACC_W(16), .BEATS(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .e(e), .f(f), .g(g), .h(h), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_data(c_out_data), .out_max(c_out_max)
    );

    typedef struct {
        logic [3:0][7:0] hs;   // element [i] is beat i
        logic [3:0][7:0] es;
        logic [3:0][7:0] fs;
        logic [3:0][7:0] gs;
        logic [15:0]     exp_data;
        logic [7:0]      exp_max;
    } frame_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        if (sel == 0) return a_in_ready;
        if (sel == 1) return b_in_ready;
        return c_in_ready;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input int sel, input logic [7:0] hh, input logic [7:0] ee,
                             input logic [7:0] ff, input logic [7:0] gg);
        bit ok;
        h = hh; e = ee; f = ff; g = gg;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy(sel)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Four beats into dut A with out_ready=1, then latency and result checks.
    task automatic run_frame(input frame_t v, input string tag);
        for (int i = 0; i < 4; i++) begin
            send_beat(0, v.hs[i], v.es[i], v.fs[i], v.gs[i]);
        end
        @(negedge clk);
        check({tag, "_valid_shift"}, {31'd0, a_out_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_valid_hold"}, {31'd0, a_out_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_valid_rise"}, {31'd0, a_out_valid}, 32'd1);
        check({tag, "_data"}, {16'd0, a_out_data}, {16'd0, v.exp_data});
        check({tag, "_max"}, {24'd0, a_out_max}, {24'd0, v.exp_max});
        @(negedge clk);
        check({tag, "_valid_drop"}, {31'd0, a_out_valid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    frame_t vecs[4];
    frame_t fr;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        // Packed lists read last beat first.
        vecs[0].hs = {4{8'd10}};  vecs[0].es = {4{8'd3}};
        vecs[0].fs = {8'd4, 8'd3, 8'd2, 8'd1};
        vecs[0].gs = {4{8'h00}};
        vecs[0].exp_data = 16'd28;   vecs[0].exp_max = 8'd4;
        vecs[1].hs = {4{8'h80}};  vecs[1].es = {4{8'hFF}};
        vecs[1].fs = {8'd3, 8'h80, 8'd7, 8'hFB};
        vecs[1].gs = {8'h02, 8'h07, 8'h07, 8'h07};
        vecs[1].exp_data = 16'hFE81; vecs[1].exp_max = 8'd7;
        vecs[2].hs = {4{8'd100}}; vecs[2].es = {4{8'd0}};
        vecs[2].fs = {4{8'h80}};
        vecs[2].gs = {8'h03, 8'h0F, 8'h0F, 8'h0F};
        vecs[2].exp_data = 16'd50;   vecs[2].exp_max = 8'h80;
        vecs[3].hs = {4{8'd0}};   vecs[3].es = {4{8'd1}};
        vecs[3].fs = {8'h80, 8'h80, 8'h81, 8'h80};
        vecs[3].gs = {8'h01, 8'h00, 8'h00, 8'h00};
        vecs[3].exp_data = 16'hFFFE; vecs[3].exp_max = 8'h81;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        e = '0; f = '0; g = '0; h = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_out_data", {16'd0, a_out_data}, 32'd0);
        check("rst_out_max", {24'd0, a_out_max}, 32'd0);
        check("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 4; k++) begin
            run_frame(vecs[k], $sformatf("vec%0d", k));
        end

        // Backpressure: result parked with in_valid held high.
        out_ready = 1'b0;
        fr.hs = {4{8'd5}}; fr.es = {4{8'd1}};
        fr.fs = {8'd0, 8'd2, 8'hFF, 8'd9}; fr.gs = {4{8'h00}};
        for (int i = 0; i < 4; i++) send_beat(0, fr.hs[i], fr.es[i], fr.fs[i], fr.gs[i]);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_valid_seen", {31'd0, seen}, 32'd1);
        in_valid = 1'b1; h = 8'd99; e = 8'd0; f = 8'h7F; g = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, a_out_valid}, 32'd1);
            check("bp_out_data", {16'd0, a_out_data}, 32'd16);
            check("bp_out_max", {24'd0, a_out_max}, 32'd9);
            check("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        run_frame(vecs[0], "after_bp");

        // Reset mid-frame discards the partial sum and the previous result.
        send_beat(0, 8'd50, 8'd0, 8'd5, 8'd0);
        send_beat(0, 8'd50, 8'd0, 8'd5, 8'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("midrst_out_max", {24'd0, a_out_max}, 32'd0);
        check("midrst_out_data", {16'd0, a_out_data}, 32'd0);
        check("midrst_in_ready", {31'd0, a_in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fr.hs = {4{8'd1}}; fr.es = {4{8'd0}}; fr.fs = {4{8'd0}}; fr.gs = {4{8'h00}};
        fr.exp_data = 16'd4; fr.exp_max = 8'd0;
        run_frame(fr, "post_rst");

        // ACC_W=10, BEATS=8: 8 x 127 overflows the 10-bit range.
        pulse_reset();
        for (int i = 0; i < 8; i++) send_beat(1, 8'd127, 8'd0, 8'd0, 8'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("w10_valid_seen", {31'd0, seen}, 32'd1);
`ifdef SIGNED_MIX_ACCUM_SATURATE_EN
        check("w10_data", {22'd0, b_out_data}, 32'h1FF);
`else
        check("w10_data", {22'd0, b_out_data}, 32'h3F8);
`endif
        check("w10_max", {24'd0, b_out_max}, 32'd0);
        @(posedge clk);
        #1;

        // BEATS=1 streaming: one result every 3 cycles.
        pulse_reset();
        h = 8'hFF; e = 8'd0; f = 8'd0; g = 8'h0F;
        in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("b1_in_ready_%0d", k), {31'd0, c_in_ready},
                  (k % 3 == 0) ? 32'd1 : 32'd0);
            check($sformatf("b1_out_valid_%0d", k), {31'd0, c_out_valid},
                  (k >= 3 && k % 3 == 0) ? 32'd1 : 32'd0);
            if (k >= 3 && k % 3 == 0) begin
                check($sformatf("b1_data_%0d", k), {16'd0, c_out_data}, 32'hFFFF);
            end
        end
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
